// File: rtl/doppler_pkg.sv
// Shared definitions for the Doppler front-end blocks.
//   state_e       : averager FSM states (accumulate / hold output)
//   SignFlipsMax  : saturation value of the sign-reversal counter
//   acc_width()   : accumulator width needed to sum 2^max_log_len samples
package doppler_pkg;

  typedef enum logic [0:0] {
    StAccum = 1'b0,
    StHold  = 1'b1
  } state_e;

  localparam logic [15:0] SignFlipsMax = 16'hFFFF;

  function automatic int unsigned acc_width(input int unsigned width,
                                            input int unsigned max_log_len);
    return width + max_log_len;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle-cycle timer for the period averager.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear to zero
//   en_i          : count this cycle (no beat accepted, block accepting input)
//   reload_i      : accepted beat; restarts the idle count
//   timeout_i     : idle cycles before expiry; zero disables expiry
//   expired_o     : single-cycle pulse on the cycle whose edge reaches timeout_i
// Once the count reaches timeout_i it holds until the next reload or clear.
module idle_timer #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic            reload_i,
  input  logic [CntW-1:0] timeout_i,
  output logic            expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            armed, done, last;

  assign armed = (timeout_i != '0);
  assign done  = armed && (cnt_q >= timeout_i);
  assign last  = armed && (cnt_q == (timeout_i - CntW'(1)));

  // A beat in the same cycle always wins over expiry.
  assign expired_o = en_i && !reload_i && last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || reload_i) begin
      cnt_d = '0;
    end else if (en_i && !done && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/zc_period_averager.sv
// Averages signed zero-crossing half-period counts over 2^len samples and emits one
// signed estimate per window. A nonzero sample of opposite sign restarts the window.
//   clk, reset_n        : clock, asynchronous active-low reset
//   clear               : synchronous clear, same effect as reset
//   log_avg_len         : log2 window length, sampled on the first beat of a window
//   timeout             : idle cycles before stale is flagged (0 disables)
//   i_tdata/tvalid/...  : input stream (i_tlast ignored)
//   o_tdata/tvalid/...  : averaged output stream (o_tlast tied low)
//   stale               : no input accepted for timeout cycles
//   sign_flips          : saturating count of sign-reversal restarts
module zc_period_averager
  import doppler_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MAX_LOG_LEN = 12,
  parameter int unsigned TIMEOUT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic [3:0]           log_avg_len,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [WIDTH-1:0]     i_tdata,
  input  logic                 i_tvalid,
  input  logic                 i_tlast,
  output logic                 i_tready,
  output logic [WIDTH-1:0]     o_tdata,
  output logic                 o_tvalid,
  output logic                 o_tlast,
  input  logic                 o_tready,
  output logic                 stale,
  output logic [15:0]          sign_flips
);

  localparam int unsigned AccW   = acc_width(WIDTH, MAX_LOG_LEN);
  localparam int unsigned CntW   = MAX_LOG_LEN + 1;
  localparam logic [3:0]  MaxLen = 4'(MAX_LOG_LEN);

  state_e                 state_q, state_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [3:0]             len_q, len_d;
  logic                   win_sign_q, win_sign_d;
  logic [WIDTH-1:0]       out_q, out_d;
  logic                   stale_q, stale_d;
  logic [15:0]            flips_q, flips_d;

  logic                   beat, first, reversal, complete, expired;
  logic [3:0]             req_len, eff_len;
  logic signed [AccW-1:0] sample_ext, base_acc, sum, avg;
  logic [CntW-1:0]        base_cnt, cnt_inc, target;
  logic                   unused_bits;

  assign i_tready   = (state_q == StAccum);
  assign o_tvalid   = (state_q == StHold);
  assign o_tlast    = 1'b0;
  assign o_tdata    = out_q;
  assign stale      = stale_q;
  assign sign_flips = flips_q;

  assign beat       = i_tvalid && i_tready;
  assign first      = (cnt_q == '0);
  assign req_len    = (log_avg_len > MaxLen) ? MaxLen : log_avg_len;
  // The first beat of a window uses the freshly sampled length.
  assign eff_len    = first ? req_len : len_q;
  assign sample_ext = {{MAX_LOG_LEN{i_tdata[WIDTH-1]}}, i_tdata};

  // Zero matches either sign, so it never triggers a restart.
  assign reversal = beat && !first && (i_tdata != '0) && (i_tdata[WIDTH-1] != win_sign_q);

  // A restart (first beat or reversal) seeds the window with this sample alone.
  assign base_acc = (first || reversal) ? '0 : acc_q;
  assign base_cnt = (first || reversal) ? '0 : cnt_q;
  assign sum      = base_acc + sample_ext;
  assign cnt_inc  = base_cnt + CntW'(1);
  assign target   = CntW'(1) << eff_len;
  assign complete = beat && !reversal && (cnt_inc == target);
  assign avg      = sum >>> eff_len;

  assign unused_bits = ^{i_tlast, avg[AccW-1:WIDTH]};

  idle_timer #(
    .CntW(TIMEOUT_W)
  ) u_idle_timer (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clear_i  (clear),
    .en_i     (state_q == StAccum),
    .reload_i (beat),
    .timeout_i(timeout),
    .expired_o(expired)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    win_sign_d = win_sign_q;
    out_d      = out_q;
    stale_d    = stale_q;
    flips_d    = flips_q;

    if (clear) begin
      state_d    = StAccum;
      acc_d      = '0;
      cnt_d      = '0;
      len_d      = '0;
      win_sign_d = 1'b0;
      out_d      = '0;
      stale_d    = 1'b0;
      flips_d    = '0;
    end else if (state_q == StHold) begin
      if (o_tready) begin
        state_d = StAccum;
      end
    end else if (beat) begin
      stale_d = 1'b0;
      if (first) begin
        len_d      = req_len;
        win_sign_d = i_tdata[WIDTH-1];
      end
      if (reversal) begin
        win_sign_d = i_tdata[WIDTH-1];
        if (flips_q != SignFlipsMax) begin
          flips_d = flips_q + 16'd1;
        end
      end
      if (complete) begin
        out_d   = avg[WIDTH-1:0];
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StHold;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end else if (expired) begin
      stale_d = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      win_sign_q <= 1'b0;
      out_q      <= '0;
      stale_q    <= 1'b0;
      flips_q    <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      win_sign_q <= win_sign_d;
      out_q      <= out_d;
      stale_q    <= stale_d;
      flips_q    <= flips_d;
    end
  end

endmodule

// File: tb/tb_zc_period_averager.sv
// Bench for zc_period_averager: directed scenarios followed by random traffic, every
// cycle compared against a queue-based window model.
module tb_zc_period_averager;

  localparam int MaxLog = 3;

  logic        clk = 1'b0;
  logic        reset_n, clear;
  logic [3:0]  log_avg_len;
  logic [7:0]  timeout;
  logic [31:0] i_tdata;
  logic        i_tvalid, i_tlast, i_tready;
  logic [31:0] o_tdata;
  logic        o_tvalid, o_tlast, o_tready, stale;
  logic [15:0] sign_flips;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  longint      m_win[$];
  bit          m_hold, m_sign, m_stale;
  int          m_len, m_idle, m_flips;
  logic [31:0] m_out;

  always #5 clk = ~clk;

  zc_period_averager #(
    .WIDTH      (32),
    .MAX_LOG_LEN(MaxLog),
    .TIMEOUT_W  (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .log_avg_len(log_avg_len),
    .timeout    (timeout),
    .i_tdata    (i_tdata),
    .i_tvalid   (i_tvalid),
    .i_tlast    (i_tlast),
    .i_tready   (i_tready),
    .o_tdata    (o_tdata),
    .o_tvalid   (o_tvalid),
    .o_tlast    (o_tlast),
    .o_tready   (o_tready),
    .stale      (stale),
    .sign_flips (sign_flips)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic model_reset();
    m_win.delete();
    m_hold  = 1'b0;
    m_sign  = 1'b0;
    m_stale = 1'b0;
    m_len   = 0;
    m_idle  = 0;
    m_flips = 0;
    m_out   = '0;
  endtask

  // One clock edge of the specified behaviour, using the inputs currently driven.
  task automatic model_step();
    longint s, d, q, total;
    if (clear) begin
      model_reset();
      return;
    end
    if (m_hold) begin
      if (o_tready) m_hold = 1'b0;
      return;
    end
    if (i_tvalid) begin
      s       = longint'($signed(i_tdata));
      m_idle  = 0;
      m_stale = 1'b0;
      if (m_win.size() == 0) begin
        m_len  = (int'(log_avg_len) > MaxLog) ? MaxLog : int'(log_avg_len);
        m_sign = (s < 0);
      end else if (s != 0 && ((s < 0) != m_sign)) begin
        m_win.delete();
        m_sign = (s < 0);
        if (m_flips < 65535) m_flips++;
      end
      m_win.push_back(s);
      if (m_win.size() == (1 << m_len)) begin
        total = 0;
        foreach (m_win[k]) total += m_win[k];
        d = longint'(1) << m_len;
        q = total / d;
        if ((total % d != 0) && (total < 0)) q = q - 1;  // floor, not truncate
        m_out  = q[31:0];
        m_hold = 1'b1;
        m_win.delete();
      end
    end else if (timeout == 8'd0) begin
      m_idle++;
    end else if (m_idle < int'(timeout)) begin
      m_idle++;
      if (m_idle == int'(timeout)) begin
        m_stale = 1'b1;
        m_win.delete();
      end
    end
  endtask

  task automatic compare_all();
    chk("i_tready", {31'd0, i_tready}, {31'd0, !m_hold});
    chk("o_tvalid", {31'd0, o_tvalid}, {31'd0, m_hold});
    chk("o_tdata", o_tdata, m_out);
    chk("stale", {31'd0, stale}, {31'd0, m_stale});
    chk("sign_flips", {16'd0, sign_flips}, 32'(m_flips));
    chk("o_tlast", {31'd0, o_tlast}, 32'd0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send(input int d);
    i_tvalid = 1'b1;
    i_tdata  = 32'(d);
    tick();
    i_tvalid = 1'b0;
  endtask

  initial begin
    int r, mag;
    bit bias;
    reset_n = 1'b0; clear = 1'b0; log_avg_len = 4'd2; timeout = 8'd0;
    i_tdata = '0; i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
    bias = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_tready", {31'd0, i_tready}, 32'd1);
    chk("rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
    chk("rst_o_tdata", o_tdata, 32'd0);
    chk("rst_stale", {31'd0, stale}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Steady positive window, one bubble with o_tready high.
    send(100); send(102); send(98); send(100);
    chk("avg_pos", o_tdata, 32'd100);
    chk("hold_tready", {31'd0, i_tready}, 32'd0);
    tick();
    chk("bubble_once", {31'd0, i_tready}, 32'd1);

    // Negative average floors toward minus infinity.
    send(-50); send(-51); send(-49); send(-52);
    chk("avg_neg_floor", o_tdata, -32'sd51);
    tick();

    // Sign reversal restarts the window.
    log_avg_len = 4'd3;
    send(10); send(10); send(10); send(-10);
    for (int k = 0; k < 7; k++) send(-10);
    chk("flip_avg", o_tdata, -32'sd10);
    chk("flip_valid", {31'd0, o_tvalid}, 32'd1);
    chk("flip_count", {16'd0, sign_flips}, 32'd1);
    tick();

    // Idle timeout marks stale and discards the partial window.
    timeout = 8'd5; log_avg_len = 4'd2;
    send(7); send(9);
    repeat (4) tick();
    chk("stale_early", {31'd0, stale}, 32'd0);
    tick();
    chk("stale_set", {31'd0, stale}, 32'd1);
    send(20);
    chk("stale_clr", {31'd0, stale}, 32'd0);
    send(20); send(20); send(20);
    chk("fresh_win", o_tdata, 32'd20);
    tick();

    // Output backpressure holds data and freezes the idle timer.
    log_avg_len = 4'd1; o_tready = 1'b0;
    send(4); send(6);
    repeat (10) tick();
    chk("bp_data", o_tdata, 32'd5);
    chk("bp_valid", {31'd0, o_tvalid}, 32'd1);
    chk("bp_stale", {31'd0, stale}, 32'd0);
    o_tready = 1'b1;
    tick();
    chk("bp_release", {31'd0, o_tvalid}, 32'd0);
    repeat (4) tick();
    chk("post_bp_idle", {31'd0, stale}, 32'd0);
    tick();
    chk("post_bp_stale", {31'd0, stale}, 32'd1);

    // Asynchronous reset mid-window.
    timeout = 8'd0; log_avg_len = 4'd2;
    send(1); send(2); send(3);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_tready", {31'd0, i_tready}, 32'd1);
    chk("arst_tdata", o_tdata, 32'd0);
    chk("arst_flips", {16'd0, sign_flips}, 32'd0);
    chk("arst_stale", {31'd0, stale}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send(8); send(8); send(8); send(12);
    chk("arst_avg", o_tdata, 32'd9);
    tick();

    // Synchronous clear beats a simultaneous beat.
    send(5); send(5);
    clear = 1'b1; i_tvalid = 1'b1; i_tdata = 32'd99;
    tick();
    clear = 1'b0; i_tvalid = 1'b0;
    chk("clr_tdata", o_tdata, 32'd0);
    send(6); send(6); send(6); send(6);
    chk("clr_avg", o_tdata, 32'd6);
    tick();

    // Length clamp, accumulator headroom, zero samples.
    log_avg_len = 4'd15;
    for (int k = 1; k <= 8; k++) send(k);
    chk("clamp_avg", o_tdata, 32'd4);
    tick();
    for (int k = 0; k < 8; k++) send(int'(32'h8000_0000));
    chk("min_avg", o_tdata, 32'h8000_0000);
    tick();
    log_avg_len = 4'd2;
    send(-4); send(0); send(-4); send(0);
    chk("zero_avg", o_tdata, -32'sd2);
    chk("zero_noflip", {16'd0, sign_flips}, 32'd0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      i_tvalid = ($urandom_range(0, 99) < 70);
      o_tready = ($urandom_range(0, 99) < 70);
      i_tlast  = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) log_avg_len = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) timeout = 8'($urandom_range(0, 8));
      if ($urandom_range(0, 19) == 0) bias = !bias;
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        i_tdata = 32'd0;
      end else if (r < 15) begin
        i_tdata = bias ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        mag = int'($urandom_range(1, 1000));
        if (r < 25) i_tdata = bias ? 32'(mag) : 32'(-mag);
        else        i_tdata = bias ? 32'(-mag) : 32'(mag);
      end
      tick();
    end
    clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
